// File: rtl/rf_pkg.sv
// Shared types, default geometry and bus helpers for the parametrised register file.
package rf_pkg;

    typedef enum logic {CLEAR, RUN} rf_state_t;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_N_RD     = 2;
    localparam int RF_BUS_MAX  = 256;
    localparam int RF_LANE_MAX = 64;

    // Lane idx of a packed bus of width-bit lanes; callers zero-extend the bus to RF_BUS_MAX.
    function automatic logic [RF_LANE_MAX-1:0] rf_lane(input logic [RF_BUS_MAX-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned width);
        logic [RF_LANE_MAX-1:0] mask;
        mask = (width >= RF_LANE_MAX) ? '1 :
               ((RF_LANE_MAX'(1) << width) - RF_LANE_MAX'(1));
        return RF_LANE_MAX'(bus >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: not-ready gating, hard-wired zero entry and write bypass.
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              i_ready,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_commit,
    input  logic [ADDR_W-1:0] i_rw,
    input  logic [DATA_W-1:0] i_w,
    output logic [DATA_W-1:0] o_rd
);

    always_comb begin
        o_rd = '0;
        if (i_ready) begin
            if ((ZERO_REG != 0) && (i_ra == '0))
                o_rd = '0;
            else if (i_commit && (i_rw == i_ra))
                o_rd = i_w;
            else
                o_rd = i_mem_data;
        end
    end

endmodule

// File: rtl/rf_bypass.sv
// Register file with same-cycle write forwarding and a post-reset hardware clear sweep.
module rf_bypass
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = RF_N_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_RD*ADDR_W-1:0]   ra,
    output logic [N_RD*DATA_W-1:0]   rd,
    input  logic [ADDR_W-1:0]        rw,
    input  logic [DATA_W-1:0]        w,
    input  logic                     we,
    output logic                     ready,
    output logic                     clr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_t         r_state, w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic              r_clr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    assign ready    = (r_state == RUN);
    assign clr_err  = r_clr_err;
    assign w_commit = ready && we && !((ZERO_REG != 0) && (rw == '0));

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == CLEAR) && (r_cnt == (ADDR_W+1)'(DEPTH - 1)))
            w_state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_clr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
                if (we)
                    r_clr_err <= 1'b1;
            end
        end
    end

    // The sweep owns the single storage write port until RUN.
    always_comb begin
        w_mem_we   = w_commit;
        w_mem_addr = rw;
        w_mem_data = w;
        if (r_state == CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt[ADDR_W-1:0];
            w_mem_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we)
            r_mem[w_mem_addr] <= w_mem_data;
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = ADDR_W'(rf_lane(RF_BUS_MAX'(ra), i, ADDR_W));

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .i_ready    (ready),
            .i_ra       (w_ra),
            .i_mem_data (r_mem[w_ra]),
            .i_commit   (w_commit),
            .i_rw       (rw),
            .i_w        (w),
            .o_rd       (rd[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_rf_bypass.sv
// Directed bench: default build (ZERO_REG 1 and 0 side by side) plus a narrow 3-port build.
module tb_rf_bypass;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 (ZERO_REG=1) and dut1 (ZERO_REG=0) share all inputs
    logic        reset;
    logic [9:0]  ra;
    logic [4:0]  rw;
    logic [31:0] w;
    logic        we;
    logic [63:0] rd0, rd1;
    logic        ready0, ready1, clr_err0, clr_err1;

    logic        reset2;
    logic [8:0]  ra2;
    logic [2:0]  rw2;
    logic [15:0] w2;
    logic        we2;
    logic [47:0] rd2;
    logic        ready2, clr_err2;

    int n_chk = 0;
    int n_err = 0;

    rf_bypass #(.ZERO_REG(1)) dut0 (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd0), .rw(rw), .w(w), .we(we),
        .ready(ready0), .clr_err(clr_err0));

    rf_bypass #(.ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd1), .rw(rw), .w(w), .we(we),
        .ready(ready1), .clr_err(clr_err1));

    rf_bypass #(.DATA_W(16), .ADDR_W(3), .N_RD(3)) dut2 (
        .clk(clk), .reset(reset2), .ra(ra2), .rd(rd2), .rw(rw2), .w(w2), .we(we2),
        .ready(ready2), .clr_err(clr_err2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with ready low, starting at the current negedge.
    task automatic wait_ready0(output int n);
        n = 0;
        while (ready0 !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        reset = 1'b1; ra = '0; rw = '0; w = '0; we = 1'b0;
        reset2 = 1'b1; ra2 = '0; rw2 = '0; w2 = '0; we2 = 1'b0;

        // sweep after a 3-cycle reset pulse
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_rd", rd0[31:0], 0);
        chk("rst_clr_err", 32'(clr_err0), 0);
        reset = 1'b0;
        ra = {5'd4, 5'd1};
        wait_ready0(n);
        chk("sweep_len", n, 32);
        chk("sweep_ready1", 32'(ready1), 1);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            chk("sweep_zero_p0", rd1[31:0], 0);
            chk("sweep_zero_p1", rd1[63:32], 0);
        end
        @(negedge clk);

        // bypass to both ports, then from storage
        we = 1'b1; rw = 5'd7; w = 32'hDEADBEEF; ra = {5'd7, 5'd7};
        #1;
        chk("byp_p0", rd0[31:0], 32'hDEADBEEF);
        chk("byp_p1", rd0[63:32], 32'hDEADBEEF);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("stor_p0", rd0[31:0], 32'hDEADBEEF);
        chk("stor_p1", rd0[63:32], 32'hDEADBEEF);
        @(negedge clk);

        // entry 0 write: discarded on dut0, ordinary on dut1
        we = 1'b1; rw = 5'd0; w = 32'h1234; ra = {5'd0, 5'd0};
        #1;
        chk("zr1_byp", rd0[31:0], 0);
        chk("zr0_byp", rd1[63:32], 32'h1234);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("zr1_stor", rd0[63:32], 0);
        chk("zr0_stor", rd1[31:0], 32'h1234);
        chk("zr1_clr_err", 32'(clr_err0), 0);
        @(negedge clk);

        // write during CLEAR cycle 10
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        we = 1'b1; rw = 5'd3; w = 32'h55;
        @(negedge clk);
        we = 1'b0;
        chk("early_clr_err", 32'(clr_err0), 1);
        wait_ready0(n);
        chk("early_rest_len", n, 21);
        chk("early_clr_err_hold", 32'(clr_err0), 1);
        chk("early_clr_err_hold1", 32'(clr_err1), 1);
        ra = {5'd7, 5'd3};
        #1;
        chk("early_e3", rd0[31:0], 0);
        chk("early_e7_reswept", rd0[63:32], 0);
        chk("early_e3_zr0", rd1[31:0], 0);
        @(negedge clk);

        // reset in RUN, then again mid-sweep
        we = 1'b1; rw = 5'd9; w = 32'h99;
        @(negedge clk);
        we = 1'b0; ra = {5'd9, 5'd9};
        #1;
        chk("pre_e9", rd0[31:0], 32'h99);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("run_rst_ready", 32'(ready0), 0);
        chk("run_rst_clr_err", 32'(clr_err0), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("clear_rd_gated", rd0[31:0], 0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready0(n);
        chk("mid_rst_len", n, 32);
        #1;
        chk("mid_rst_e9", rd0[31:0], 0);
        chk("mid_rst_e9_zr0", rd1[63:32], 0);
        @(negedge clk);

        // narrow 3-port build
        reset2 = 1'b0;
        n = 0;
        while (ready2 !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("p_sweep_len", n, 8);
        we2 = 1'b1; rw2 = 3'd5; w2 = 16'hA5A5; ra2 = {3'd5, 3'd5, 3'd5};
        #1;
        chk("p_byp0", 32'(rd2[15:0]), 32'hA5A5);
        chk("p_byp1", 32'(rd2[31:16]), 32'hA5A5);
        chk("p_byp2", 32'(rd2[47:32]), 32'hA5A5);
        @(negedge clk);
        we2 = 1'b0;
        #1;
        chk("p_stor0", 32'(rd2[15:0]), 32'hA5A5);
        chk("p_stor1", 32'(rd2[31:16]), 32'hA5A5);
        chk("p_stor2", 32'(rd2[47:32]), 32'hA5A5);
        chk("p_clr_err", 32'(clr_err2), 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rf_bypass.md
# rf_bypass

Parametrised register file for the MIPS datapath. It generalises the fixed 32x32 file to configurable width, depth and read-port count. It writes on the rising edge, forwards same-cycle writes to the read ports, and clears itself by a hardware sweep after reset. It sits between decode (read addresses) and writeback (write port), and its `ready` output gates pipeline start-up.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth = 2^ADDR_W.
- `N_RD`, default 2: number of read ports, 1..4.
- `ZERO_REG`, default 1: 1 makes entry 0 hard-wired to zero; 0 makes it an ordinary register.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ra` in N_RD*ADDR_W: packed read addresses; port i is `ra[i*ADDR_W +: ADDR_W]`.
- `rd` out N_RD*DATA_W: packed read data, same packing as `ra`.
- `rw` in ADDR_W: write address.
- `w` in DATA_W: write data.
- `we` in 1: write enable.
- `ready` out 1: sweep finished; reads and writes are valid.
- `clr_err` out 1: sticky flag, set when `we` arrives while `ready`=0.

## Operation
- States: CLEAR, RUN.
- `reset`=1: state becomes CLEAR, the sweep counter goes to 0 and `clr_err` goes to 0. No entry is written while reset is high.
- CLEAR, reset low:
  - each cycle, entry[counter] is written with 0 and the counter increments.
  - once entry 2^ADDR_W-1 is written, the state becomes RUN.
  - `we` is ignored; if `we`=1, `clr_err` is set.
- RUN:
  - if `we`=1 and not (ZERO_REG=1 and `rw`=0), entry[`rw`] gets `w` on the rising edge.
  - writes to entry 0 with ZERO_REG=1 are discarded silently and do not set `clr_err`.
- Reads are combinational, per port:
  - `ready`=0 gives 0.
  - ZERO_REG=1 and address 0 gives 0.
  - in RUN, a same-cycle write that will commit to the same address returns `w` (bypass).
  - otherwise the stored entry is returned.
- Multiple ports reading the same address, including a bypass hit, all return the same value.
- `clr_err` holds until the next reset.

## Timing
- Output values during reset and CLEAR:
  - `ready` = 0.
  - every `rd` lane = 0.
  - `clr_err` = 0 on the cycle after reset is sampled.
- Reset deasserted before edge k: entries 0..D-1 (D = 2^ADDR_W) are cleared on edges k..k+D-1. `ready` rises after edge k+D-1, so CLEAR lasts exactly D cycles.
- Reset asserted mid-sweep restarts the sweep from entry 0 with a full D cycles.
- Reset asserted in RUN drops `ready` on the next edge. Entries are zeroed again by the sweep.
- Write latency: a RUN write is visible through bypass in the same cycle and from storage from the next cycle onward. The register-to-read latency is effectively zero cycles.
- The first write is accepted on the first edge with `ready`=1.
- No backpressure: `we` is single-cycle fire-and-forget.

## Structure
- Shared package `rf_pkg`:
  - state enum `rf_state_t` {CLEAR, RUN}.
  - default width/depth constants.
  - a function that extracts lane i of a packed bus.
- One sub-module, `rf_read_port`: one instance per read port, generated N_RD times. It does the zero-register, not-ready and bypass muxing.
- Storage is a flat array of 2^ADDR_W x DATA_W. The counter width is ADDR_W+1 so termination is detectable.

## Test plan
- Sweep:
  - stimulus: default params; pulse reset 3 cycles, then release.
  - required: `ready`=0 for exactly 32 cycles, then 1; all 32 entries read 0.
- Bypass:
  - stimulus: in RUN, `we`=1, `rw`=7, `w`=0xDEADBEEF, port0 `ra`=7, port1 `ra`=7.
  - required: both lanes show 0xDEADBEEF in the same cycle.
  - follow-up: next cycle with `we`=0, both lanes still show 0xDEADBEEF.
- Zero register:
  - ZERO_REG=1, write 0x1234 to entry 0: reads 0 in the same cycle and after; `clr_err` stays 0.
  - ZERO_REG=0, same write: reads 0x1234 via bypass and afterwards.
- Early write:
  - stimulus: `we`=1, `rw`=3, `w`=0x55 during CLEAR cycle 10.
  - required: `clr_err`=1 and stays 1.
  - after `ready`, entry 3 reads 0.
- Mid-sweep reset:
  - stimulus: reset at CLEAR cycle 20.
  - required: `ready` rises exactly 32 cycles after reset release; an entry written before the reset reads 0.
- Parametrised build:
  - parameters: DATA_W=16, ADDR_W=3, N_RD=3.
  - stimulus: write 0xA5A5 to entry 5, then read it on all 3 ports.
  - required: all lanes show 0xA5A5; the sweep lasts exactly 8 cycles.
